// File: rtl/bmem_responder_pkg.sv
// Shared types and constants for the burst-memory responder.
//   - Burst geometry: four 64-bit beats per 32-byte line.
//   - bmem_rd_entry_t: one queued read (line address, snapshotted line data,
//     cycles left before the burst may start).
//   - bmem_state_e: request-side FSM states.
package bmem_responder_pkg;

  localparam int BMEM_BURST_LEN  = 4;
  localparam int BMEM_LINE_BYTES = 32;
  localparam int BMEM_WORD_W     = 64;
  localparam int BMEM_LINE_W     = BMEM_BURST_LEN * BMEM_WORD_W;
  localparam int BMEM_OFFSET_W   = $clog2(BMEM_LINE_BYTES);

  typedef struct packed {
    logic [31:0]            addr;
    logic [BMEM_LINE_W-1:0] data;
    logic [3:0]             countdown;
  } bmem_rd_entry_t;

  typedef enum logic {
    ST_IDLE,
    ST_WBURST
  } bmem_state_e;

  // Line base address: byte offset within the line forced to zero.
  function automatic logic [31:0] line_base(input logic [31:0] a);
    return a & ~32'(BMEM_LINE_BYTES - 1);
  endfunction

endpackage

// File: rtl/bmem_responder_sync_fifo.sv
// Read-request queue for the burst-memory responder.
//   clk, rst       : clock, synchronous active-low reset (flushes the queue)
//   push/push_data : enqueue one read entry (caller guarantees !full)
//   pop            : drop the head entry (caller guarantees !empty)
//   full/empty     : occupancy flags; count: number of live entries
//   head/head_next : oldest and second-oldest entries
// Every slot's countdown decrements each cycle (floor 0); the slot being
// written this cycle takes the pushed value instead.
module sync_fifo
  import bmem_responder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  bmem_rd_entry_t         push_data,
  input  logic                   pop,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output bmem_rd_entry_t         head,
  output bmem_rd_entry_t         head_next
);

  localparam int AW = $clog2(DEPTH);

  bmem_rd_entry_t slot_q [DEPTH];
  bmem_rd_entry_t slot_d [DEPTH];
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]    count_q, count_d;

  always_comb begin
    slot_d = slot_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_q[i].countdown != 4'd0) begin
        slot_d[i].countdown = slot_q[i].countdown - 4'd1;
      end
    end
    if (push) begin
      slot_d[wr_ptr_q] = push_data;
    end
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  // NOTE: slot storage carries no reset; the pointers and count alone decide
  // which slots are live, so stale slot contents are never observed.
  always_ff @(posedge clk) begin
    slot_q <= slot_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign full      = (count_q == (AW+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head      = slot_q[rd_ptr_q];
  assign head_next = slot_q[rd_ptr_q + AW'(1)];

endmodule

// File: rtl/bmem_responder.sv
// Burst-memory responder: far end of the bmem line port.
//   clk, rst     : clock, synchronous active-low reset
//   bmem_addr    : request line address (bits [4:0] ignored)
//   bmem_read    : read request
//   bmem_write   : write request / write beat valid
//   bmem_wdata   : write beat data
//   bmem_ready   : request accepted this cycle when high with read or write
//   bmem_raddr   : line address of the current read beat
//   bmem_rdata   : read beat data
//   bmem_rvalid  : read beat valid
//   proto_err    : sticky protocol-violation flag
// Reads snapshot the whole line at accept time and return four beats
// READ_LATENCY cycles later, strictly in order. Writes take four beats,
// committing one 64-bit word per beat.
module bmem_responder
  import bmem_responder_pkg::*;
#(
  parameter int NUM_LINES    = 1024,
  parameter int READ_LATENCY = 4,
  parameter int QUEUE_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bmem_addr,
  input  logic        bmem_read,
  input  logic        bmem_write,
  input  logic [63:0] bmem_wdata,
  output logic        bmem_ready,
  output logic [31:0] bmem_raddr,
  output logic [63:0] bmem_rdata,
  output logic        bmem_rvalid,
  output logic        proto_err
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;
  // The beat register loads one edge before the beat is sampled, and the
  // countdown is checked before that edge's decrement, so a head entry may
  // launch once its countdown has fallen to 2.
  localparam logic [3:0] LAUNCH_AT = 4'd2;

  // Line storage, written one 64-bit word at a time.
  logic [BMEM_BURST_LEN-1:0][BMEM_WORD_W-1:0] line_mem [NUM_LINES];

  // Request side
  bmem_state_e      state_q, state_d;
  logic [1:0]       beat_cnt_q, beat_cnt_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic             err_q, err_d;
  logic             rd_accept, wr_accept;
  logic             mem_we;
  logic [IDX_W-1:0] mem_widx;
  logic [1:0]       mem_wword;
  logic [IDX_W-1:0] req_idx;

  // Return side
  logic             rvalid_q, rvalid_d;
  logic [1:0]       rbeat_q, rbeat_d;
  logic [63:0]      rdata_q, rdata_d;
  logic [31:0]      raddr_q, raddr_d;
  logic             last_beat, launch_ok;
  logic [1:0]       nxt_beat;
  bmem_rd_entry_t   launch_src;

  // Queue
  bmem_rd_entry_t   push_entry, head, head_next;
  logic             fifo_full, fifo_empty, fifo_pop;
  logic [CNT_W-1:0] fifo_count;

  assign req_idx = bmem_addr[BMEM_OFFSET_W +: IDX_W];

  // Ready depends only on reset, state and queue occupancy; it is held low
  // while reset is asserted so nothing is accepted during a reset cycle.
  assign bmem_ready = rst && (state_q == ST_IDLE) && !fifo_full;
  assign wr_accept  = bmem_ready && bmem_write;
  assign rd_accept  = bmem_ready && bmem_read && !bmem_write;

  assign push_entry = '{addr:      line_base(bmem_addr),
                        data:      line_mem[req_idx],
                        countdown: 4'(READ_LATENCY)};

  sync_fifo #(.DEPTH(QUEUE_DEPTH)) u_rd_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_accept),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (head),
    .head_next (head_next)
  );

  // Request FSM: write bursts and protocol checking.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    wr_idx_d   = wr_idx_q;
    err_d      = err_q;
    mem_we     = 1'b0;
    mem_widx   = wr_idx_q;
    mem_wword  = beat_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bmem_read && bmem_write) err_d = 1'b1;
        if (wr_accept) begin
          mem_we     = 1'b1;
          mem_widx   = req_idx;
          mem_wword  = 2'd0;
          wr_idx_d   = req_idx;
          beat_cnt_d = 2'd1;
          state_d    = ST_WBURST;
        end
      end
      ST_WBURST: begin
        if (bmem_read) err_d = 1'b1;
        if (bmem_write) begin
          mem_we = 1'b1;
          if (beat_cnt_q == 2'd3) begin
            beat_cnt_d = 2'd0;
            state_d    = ST_IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + 2'd1;
          end
        end else begin
          // Missing beat: hold the counter and wait for the next one.
          err_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Return engine: streams the head entry, then launches the next eligible
  // entry on the same edge the finished one pops, so bursts run gap-free.
  always_comb begin
    last_beat = rvalid_q && (rbeat_q == 2'd3);
    fifo_pop  = last_beat;
    nxt_beat  = rbeat_q + 2'd1;
    if (last_beat) begin
      launch_src = head_next;
      launch_ok  = (fifo_count >= CNT_W'(2)) && (head_next.countdown <= LAUNCH_AT);
    end else begin
      launch_src = head;
      launch_ok  = !fifo_empty && (head.countdown <= LAUNCH_AT);
    end

    rvalid_d = rvalid_q;
    rbeat_d  = rbeat_q;
    rdata_d  = rdata_q;
    raddr_d  = raddr_q;
    if (rvalid_q && !last_beat) begin
      rbeat_d = nxt_beat;
      rdata_d = head.data[{nxt_beat, 6'b0} +: 64];
    end else if (launch_ok) begin
      rvalid_d = 1'b1;
      rbeat_d  = 2'd0;
      rdata_d  = launch_src.data[63:0];
      raddr_d  = launch_src.addr;
    end else begin
      rvalid_d = 1'b0;
      rbeat_d  = 2'd0;
    end
  end

  // NOTE: the line array is deliberately left out of reset so it maps onto
  // RAM and keeps words committed before a reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      line_mem[mem_widx][mem_wword] <= bmem_wdata;
    end
  end

  // NOTE: all state updates use non-blocking assignment so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      beat_cnt_q <= 2'd0;
      wr_idx_q   <= '0;
      err_q      <= 1'b0;
      rvalid_q   <= 1'b0;
      rbeat_q    <= 2'd0;
      rdata_q    <= '0;
      raddr_q    <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      wr_idx_q   <= wr_idx_d;
      err_q      <= err_d;
      rvalid_q   <= rvalid_d;
      rbeat_q    <= rbeat_d;
      rdata_q    <= rdata_d;
      raddr_q    <= raddr_d;
    end
  end

  assign bmem_raddr  = raddr_q;
  assign bmem_rdata  = rdata_q;
  assign bmem_rvalid = rvalid_q;
  assign proto_err   = err_q;

endmodule

// File: doc/bmem_responder.md
# bmem_responder

Synthesizable burst-memory responder: the far end of the single `bmem` port the CPU top drives through its cache arbiter. It accepts 32-byte line reads and writes, returns read lines as four 64-bit beats after a fixed latency, and commits write bursts into an internal line array. Used as the on-chip backing memory for FPGA bring-up and as the golden DUT-side memory in top-level benches.

## Interface
- `NUM_LINES`, 1024: lines of storage (power of 2); address bits above the index are ignored (modulo wrap).
- `READ_LATENCY`, 4: cycles from read accept to first beat; legal range 2..15.
- `QUEUE_DEPTH`, 4: outstanding read requests held (power of 2, ≥2).

- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-low reset.
- `bmem_addr` in 32: request line address; bits [4:0] ignored (treated as 0).
- `bmem_read` in 1: read request.
- `bmem_write` in 1: write request/beat valid.
- `bmem_wdata` in 64: write beat data.
- `bmem_ready` out 1: request accepted this cycle when high with read or write.
- `bmem_raddr` out 32: line address of the current read beat, bits [4:0]=0.
- `bmem_rdata` out 64: read beat data.
- `bmem_rvalid` out 1: read beat valid.
- `proto_err` out 1: sticky protocol-violation flag.

## Operation
- States: IDLE, WBURST (beats 1..3), no others. Read return engine runs independently of state.
- IDLE: `bmem_ready` = !queue_full. Accept on `bmem_ready && (bmem_read || bmem_write)`.
- Read accept: full 256-bit line snapshotted from array into queue entry {line addr, data, countdown=READ_LATENCY}. Snapshot at accept ⇒ later writes never alter an accepted read.
- Write accept: beat 0 written to word 0 of line at accept; latch line addr; go WBURST, beat counter=1. `bmem_ready` low in WBURST. Each cycle with `bmem_write` high writes word[counter] at latched addr; after beat 3 return to IDLE.
- `bmem_read && bmem_write` same cycle in IDLE: write wins, read not accepted, `proto_err` set.
- `bmem_write` low during WBURST: no commit that cycle, counter holds, `proto_err` set; burst resumes on next high. `bmem_read` high in WBURST sets `proto_err`, ignored.
- Return engine: head entry eligible when its countdown expires; streams 4 beats, words 0..3 in order, `bmem_rvalid` high 4 contiguous cycles, then pops. Next eligible entry starts the following cycle (bursts may be back-to-back, no gap). Strict in-order return.
- Queue full: `bmem_ready` low; becomes high the cycle after the head's last beat pops.
- Write commit to a line being concurrently streamed: stream unaffected (snapshot).
- Address index = `bmem_addr[5+$clog2(NUM_LINES)-1:5]`; `bmem_raddr` echoes full request addr with [4:0] cleared.

## Timing
- Reset (rst low at edge): `bmem_ready`=0, `bmem_rvalid`=0, `bmem_raddr`=0, `bmem_rdata`=0, `proto_err`=0, state IDLE, queue flushed, beat counter 0. Array contents not reset; beats already committed before a mid-burst reset remain. `bmem_ready` goes high the first cycle after rst returns high.
- All outputs registered except `bmem_ready` (function of state and queue count only, never of request inputs).
- Read accepted at edge T: beats at T+L, T+L+1, T+L+2, T+L+3 (L=READ_LATENCY) when queue otherwise idle.
- Back-to-back reads accepted at T and T+1: second burst T+L+4..T+L+7.
- Write at T: beats T..T+3 (no stall); `bmem_ready` low T+1..T+3, high T+4. Read accepted at T+4 observes all four beats.
- Reads and writes overlap freely: write may be accepted while reads stream.

## Structure
- Shared package (`rv32i_types` alongside existing bmem types): `BMEM_BURST_LEN=4`, `BMEM_LINE_BYTES=32`, typedef `bmem_rd_entry_t` {addr[31:0], data[255:0], countdown[3:0]}.
- Sub-module: `sync_fifo` (parameterized width/depth, push/pop/full/empty/head) holding `bmem_rd_entry_t`; countdown decremented in place for all valid entries each cycle, floor 0.
- Array: `NUM_LINES`×256-bit, per-64-bit-word write enables.

## Test plan
- Reset then write line 0x0000_1000 beats {A0,A1,A2,A3} at T..T+3, read at T+4 → rvalid T+8..T+11, raddr 0x1000, rdata A0..A3; ready low T+1..T+3.
- Four reads 0x100,0x120,0x140,0x160 on consecutive cycles (L=4) → 16 contiguous rvalid beats, in order, 5th read stalled (ready low) until first burst pops.
- Read 0x200 accepted at T, write 0x200 {B0..B3} at T+1 → returned data is pre-write contents; subsequent read returns B0..B3.
- Write burst with `bmem_write` dropped at beat 2 for one cycle → proto_err=1, line still ends {C0..C3}, ready high one cycle later than nominal.
- Assert rst low mid-WBURST and with 2 reads queued → next cycle rvalid=0, ready=0; after release ready=1, no stale beats emitted, committed beats retained.
- Address 0x0000_101F and 0x0010_1000 with NUM_LINES=1024 → both alias line 0x1000 index; raddr echoes 0x0000_1000 / 0x0010_1000.
